// File: rtl/au_arbiter_pkg.sv
// Shared types and constants for the au_arbiter block: FSM state encoding,
// arithmetic-unit opcodes and an id-width helper.
package au_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int unsigned OP_ADD = 0;
    localparam int unsigned OP_SUB = 1;
    localparam int unsigned OP_MUL = 2;
    localparam int unsigned OP_DIV = 3;
    localparam int unsigned OP_SHL = 4;
    localparam int unsigned OP_SHR = 5;
    localparam int unsigned OP_ROL = 6;
    localparam int unsigned OP_ROR = 7;

    // Requester index width; a single requester still gets a 1-bit id.
    function automatic int unsigned id_width(input int unsigned nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

endpackage

// File: rtl/au_arbiter_if.sv
// Request, arithmetic-unit and response signals of au_arbiter.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high.
interface au_arbiter_if
    import au_arbiter_pkg::*;
#(
    parameter int N    = 4,
    parameter int M    = 4,
    parameter int NREQ = 2
);
    localparam int IDW = id_width(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*N-1:0]     req_a;
    logic [NREQ*N-1:0]     req_b;
    logic [NREQ*(M-1)-1:0] req_op;

    logic [N-1:0]          au_a;
    logic [N-1:0]          au_b;
    logic [M-2:0]          au_instruction;
    logic [N-1:0]          au_out;

    logic                  resp_valid;
    logic                  resp_ready;
    logic [N-1:0]          resp_data;
    logic [IDW-1:0]        resp_id;
    logic                  resp_err;

    modport slave (
        input  req_valid, req_a, req_b, req_op, au_out, resp_ready,
        output req_ready, au_a, au_b, au_instruction, resp_valid, resp_data, resp_id, resp_err
    );

    modport master (
        output req_valid, req_a, req_b, req_op, au_out, resp_ready,
        input  req_ready, au_a, au_b, au_instruction, resp_valid, resp_data, resp_id, resp_err
    );

endinterface

// File: rtl/au_rr_arbiter.sv
// Combinational round-robin picker: one-hot grant of the first valid request
// found at ptr, ptr+1, ... wrapping at NREQ.
module au_rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  gnt_idx,
    output logic            any
);
    localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

    logic [NREQ-1:0] rot;
    logic [IDW:0]    sum;

    // rot[i] is the request at priority position i relative to ptr
    assign rot = NREQ'({req, req} >> ptr);

    always_comb begin
        any = 1'b0;
        sum = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                any = 1'b1;
                sum = {1'b0, ptr} + (IDW+1)'(i);
            end
        end
        if (sum >= NREQ_W) begin
            sum = sum - NREQ_W;
        end
        gnt_idx = sum[IDW-1:0];
        grant   = any ? (NREQ'(1) << gnt_idx) : '0;
    end

endmodule

// File: rtl/au_arbiter.sv
// Round-robin sequencer sharing one external arithmetic unit between NREQ requesters.
// Optional AU_ARBITER_DIVZERO_CHECK_EN: divide by zero returns all ones with resp_err set.
module au_arbiter
    import au_arbiter_pkg::*;
#(
    parameter int N    = 4,
    parameter int M    = 4,
    parameter int NREQ = 2
) (
    input  logic         clk,
    input  logic         rst,
    au_arbiter_if.slave  bus,
    output state_e       dbg_state
);
    localparam int OPW = M - 1;
    localparam int IDW = id_width(NREQ);
    localparam logic [IDW-1:0] LAST = IDW'(NREQ - 1);

    state_e          state, state_nx;
    logic [IDW-1:0]  rr_ptr, gnt_idx, cur_id;
    logic [NREQ-1:0] grant;
    logic            any_req;
    logic            take;
    logic [N-1:0]    sel_a, sel_b;
    logic [OPW-1:0]  sel_op;
    logic [N-1:0]    res_data;
    logic            res_err;

    au_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
        .req     (bus.req_valid),
        .ptr     (rr_ptr),
        .grant   (grant),
        .gnt_idx (gnt_idx),
        .any     (any_req)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (any_req) state_nx = ST_EXEC;
            ST_EXEC: state_nx = ST_RESP;
            ST_RESP: if (bus.resp_ready) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Grants are only visible in IDLE and never while reset is held
    always_comb begin
        bus.req_ready = '0;
        take          = 1'b0;
        if (state == ST_IDLE && !rst) begin
            bus.req_ready = grant;
            take          = any_req;
        end
    end

    assign dbg_state = state;

    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_idx == IDW'(i)) begin
                sel_a  = bus.req_a[i*N +: N];
                sel_b  = bus.req_b[i*N +: N];
                sel_op = bus.req_op[i*OPW +: OPW];
            end
        end
    end

    always_comb begin
        res_data = bus.au_out;
        res_err  = 1'b0;
`ifdef AU_ARBITER_DIVZERO_CHECK_EN
        if (bus.au_instruction == OPW'(OP_DIV) && bus.au_b == '0) begin
            res_data = '1;
            res_err  = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.au_a           <= '0;
            bus.au_b           <= '0;
            bus.au_instruction <= '0;
            rr_ptr             <= '0;
            cur_id             <= '0;
            bus.resp_valid     <= 1'b0;
            bus.resp_data      <= '0;
            bus.resp_id        <= '0;
            bus.resp_err       <= 1'b0;
        end else begin
            if (take) begin
                bus.au_a           <= sel_a;
                bus.au_b           <= sel_b;
                bus.au_instruction <= sel_op;
                cur_id             <= gnt_idx;
                rr_ptr             <= (gnt_idx == LAST) ? '0 : gnt_idx + IDW'(1);
            end
            if (state == ST_EXEC) begin
                bus.resp_data  <= res_data;
                bus.resp_err   <= res_err;
                bus.resp_id    <= cur_id;
                bus.resp_valid <= 1'b1;
            end else if (bus.resp_valid && bus.resp_ready) begin
                bus.resp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_au_arbiter.sv
// Directed and random stimulus for au_arbiter with a behavioural arithmetic unit
// and a queue of expected responses.
module tb_au_arbiter;
    import au_arbiter_pkg::*;

    localparam int N    = 4;
    localparam int M    = 4;
    localparam int NREQ = 2;
    localparam int OPW  = M - 1;
    localparam int IDW  = 1;
    localparam int W    = 1 + IDW + N;

    logic   clk = 1'b0;
    logic   rst;
    state_e dbg_state;
    int     checks = 0;
    int     errors = 0;
    logic [W-1:0] exp_q[$];

    au_arbiter_if #(.N(N), .M(M), .NREQ(NREQ)) bus ();

    au_arbiter #(.N(N), .M(M), .NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] alu(input logic [N-1:0] a, input logic [N-1:0] b,
                                         input logic [OPW-1:0] op);
        logic [N-1:0] r;
        int sh;
        sh = int'(b[1:0]);
        case (op)
            3'd0: r = a + b;
            3'd1: r = a - b;
            3'd2: r = a * b;
            3'd3: r = (b == '0) ? '0 : a / b;
            3'd4: r = a << sh;
            3'd5: r = a >> sh;
            3'd6: r = (a << sh) | (a >> (N - sh));
            default: r = (a >> sh) | (a << (N - sh));
        endcase
        return r;
    endfunction

    assign bus.au_out = alu(bus.au_a, bus.au_b, bus.au_instruction);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int r, input logic [N-1:0] a, input logic [N-1:0] b,
                           input logic [OPW-1:0] op);
        bus.req_a[r*N +: N]       = a;
        bus.req_b[r*N +: N]       = b;
        bus.req_op[r*OPW +: OPW]  = op;
    endtask

    // Drives one request, checks the grant and the registered operands.
    // With track set, the expected response is queued and the 2-cycle latency checked.
    task automatic issue(input int r, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [OPW-1:0] op, input logic [N-1:0] exp_d,
                         input logic exp_e, input bit track);
        int cyc;
        cyc = 0;
        @(negedge clk);
        set_req(r, a, b, op);
        bus.req_valid[r] = 1'b1;
        #1;
        while (bus.req_ready[r] !== 1'b1 && cyc < 10) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        check("grant", 32'(bus.req_ready), 32'(1) << r);
        if (track) exp_q.push_back({exp_e, IDW'(r), exp_d});
        @(posedge clk);
        #1;
        bus.req_valid[r] = 1'b0;
        check("au_a", 32'(bus.au_a), 32'(a));
        check("au_b", 32'(bus.au_b), 32'(b));
        check("au_op", 32'(bus.au_instruction), 32'(op));
        check("exec_state", 32'(dbg_state), 32'(ST_EXEC));
        check("exec_no_valid", 32'(bus.resp_valid), 32'(0));
        if (track) begin
            @(posedge clk);
            #1;
            check("latency", 32'(bus.resp_valid), 32'(1));
        end
    endtask

    // Waits for a response, holds backpressure for stall cycles, then accepts it.
    task automatic collect(input int stall);
        int cyc;
        logic [W-1:0] exp;
        cyc = 0;
        while (bus.resp_valid !== 1'b1 && cyc < 10) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("resp_arrive", 32'(bus.resp_valid), 32'(1));
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL sb_empty observed=0 expected=1");
            return;
        end
        exp = exp_q.pop_front();
        bus.resp_ready = 1'b0;
        for (int s = 0; s < stall; s++) begin
            check("bp_hold", 32'({bus.resp_err, bus.resp_id, bus.resp_data}), 32'(exp));
            check("bp_valid", 32'(bus.resp_valid), 32'(1));
            check("bp_no_ready", 32'(bus.req_ready), 32'(0));
            @(posedge clk);
            #1;
        end
        bus.resp_ready = 1'b1;
        check("resp_data", 32'(bus.resp_data), 32'(exp[N-1:0]));
        check("resp_id", 32'(bus.resp_id), 32'(exp[N +: IDW]));
        check("resp_err", 32'(bus.resp_err), 32'(exp[W-1]));
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
        check("resp_done", 32'(bus.resp_valid), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_ptr;
        int cyc;
        logic [N-1:0] ea, eb, ed;
        logic [OPW-1:0] eop;
        logic ee;
        int er;

        // Reset: requests present must not be granted while rst is high
        rst            = 1'b1;
        bus.resp_ready = 1'b0;
        bus.req_a      = {4'd2, 4'd1};
        bus.req_b      = {4'd3, 4'd4};
        bus.req_op     = {3'd1, 3'd0};
        bus.req_valid  = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(bus.req_ready), 32'(0));
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        check("rst_au_a", 32'(bus.au_a), 32'(0));
        check("rst_au_b", 32'(bus.au_b), 32'(0));
        check("rst_au_op", 32'(bus.au_instruction), 32'(0));
        check("rst_resp_valid", 32'(bus.resp_valid), 32'(0));
        check("rst_resp_data", 32'(bus.resp_data), 32'(0));
        check("rst_resp_id", 32'(bus.resp_id), 32'(0));
        check("rst_resp_err", 32'(bus.resp_err), 32'(0));
        bus.req_valid = 2'b00;
        rst           = 1'b0;

        // Single request and modulo wrap-around
        issue(0, 4'd3, 4'd5, 3'd0, 4'd8, 1'b0, 1'b1);
        collect(0);
        issue(1, 4'd9, 4'd9, 3'd0, 4'd2, 1'b0, 1'b1);
        collect(0);
        issue(0, 4'd4, 4'd5, 3'd2, 4'd4, 1'b0, 1'b1);
        collect(0);
        issue(1, 4'd3, 4'd5, 3'd1, 4'd14, 1'b0, 1'b1);
        collect(0);
        issue(0, 4'b1001, 4'd1, 3'd6, 4'b0011, 1'b0, 1'b1);
        collect(0);

        // Contention from reset: grants must alternate 0,1,0,1
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst           = 1'b0;
        bus.req_a     = {4'd2, 4'd1};
        bus.req_b     = {4'd3, 4'd4};
        bus.req_op    = {3'd1, 3'd0};
        bus.req_valid = 2'b11;
        exp_ptr       = 0;
        for (int k = 0; k < 4; k++) begin
            cyc = 0;
            #1;
            while (bus.req_ready === '0 && cyc < 10) begin
                @(negedge clk);
                #1;
                cyc++;
            end
            check("rr_grant", 32'(bus.req_ready), 32'(1) << exp_ptr);
            exp_q.push_back({1'b0, IDW'(exp_ptr), (exp_ptr == 0) ? 4'd5 : 4'd15});
            @(posedge clk);
            #1;
            collect(0);
            exp_ptr = (exp_ptr + 1) % NREQ;
        end
        bus.req_valid = 2'b00;

        // Backpressure with a request waiting behind the stalled response
        issue(0, 4'd6, 4'd7, 3'd1, 4'd15, 1'b0, 1'b1);
        set_req(1, 4'd2, 4'd2, 3'd0);
        bus.req_valid[1] = 1'b1;
        collect(5);
        issue(1, 4'd2, 4'd2, 3'd0, 4'd4, 1'b0, 1'b1);
        collect(0);

        // Divide by zero
`ifdef AU_ARBITER_DIVZERO_CHECK_EN
        issue(0, 4'd7, 4'd0, 3'd3, 4'd15, 1'b1, 1'b1);
`else
        issue(0, 4'd7, 4'd0, 3'd3, alu(4'd7, 4'd0, 3'd3), 1'b0, 1'b1);
`endif
        collect(0);
        issue(1, 4'd14, 4'd3, 3'd3, 4'd4, 1'b0, 1'b1);
        collect(1);

        // Reset in EXEC aborts the op and restores the pointer
        issue(0, 4'd5, 4'd1, 3'd0, 4'd6, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
        check("mid_rst_au_a", 32'(bus.au_a), 32'(0));
        check("mid_rst_au_b", 32'(bus.au_b), 32'(0));
        check("mid_rst_valid", 32'(bus.resp_valid), 32'(0));
        check("mid_rst_data", 32'(bus.resp_data), 32'(0));
        check("mid_rst_ready", 32'(bus.req_ready), 32'(0));
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("mid_rst_no_resp", 32'(bus.resp_valid), 32'(0));
        end
        set_req(0, 4'd1, 4'd1, 3'd0);
        set_req(1, 4'd8, 4'd1, 3'd0);
        bus.req_valid = 2'b11;
        #1;
        check("post_rst_grant", 32'(bus.req_ready), 32'(1));
        exp_q.push_back({1'b0, IDW'(0), 4'd2});
        @(posedge clk);
        #1;
        bus.req_valid = 2'b00;
        collect(0);

        // Random operations
        for (int k = 0; k < 8; k++) begin
            er  = $urandom_range(0, NREQ - 1);
            ea  = N'($urandom_range(0, 15));
            eb  = N'($urandom_range(0, 15));
            eop = OPW'($urandom_range(0, 7));
            ed  = alu(ea, eb, eop);
            ee  = 1'b0;
`ifdef AU_ARBITER_DIVZERO_CHECK_EN
            if (eop == 3'd3 && eb == '0) begin
                ed = '1;
                ee = 1'b1;
            end
`endif
            issue(er, ea, eb, eop, ed, ee, 1'b1);
            collect($urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
